// File: rtl/mem_wb_stage.sv
// Back-end of the 8-bit pipeline: EX/MEM latch, data memory, MEM/WB latch,
// register-file write port and operand-forwarding selects.
module mem_wb_stage #(
  parameter int DW = 8,
  parameter int RW = 3,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ex_valid,
  input  logic          ex_regwrite,
  input  logic          ex_memread,
  input  logic          ex_memwrite,
  input  logic [RW-1:0] ex_rd,
  input  logic [DW-1:0] ex_alu_out,
  input  logic [DW-1:0] ex_store_data,
  input  logic [RW-1:0] id_ex_rs,
  input  logic [RW-1:0] id_ex_rt,
  output logic [DW-1:0] exmem_alu,
  output logic          wb_we,
  output logic [RW-1:0] wb_wa,
  output logic [DW-1:0] wb_wd,
  output logic [1:0]    forwardA,
  output logic [1:0]    forwardB,
  output logic [7:0]    store_cnt
);

  localparam int DEPTH = 1 << AW;

  logic          em_valid;
  logic          em_regwrite;
  logic          em_memread;
  logic          em_memwrite;
  logic [RW-1:0] em_rd;
  logic [DW-1:0] em_alu;
  logic [DW-1:0] em_sdata;

  logic          mw_valid;
  logic          mw_regwrite;
  logic [RW-1:0] mw_rd;
  logic [DW-1:0] mw_data;

  logic [DW-1:0] dmem [DEPTH];
  logic [AW-1:0] addr;
  logic [DW-1:0] rd_data;
  logic          em_load;
  logic          em_store;
  logic          em_fwd_ok;

  assign addr     = em_alu[AW-1:0];
  assign rd_data  = dmem[addr];
  // A store wins over a load flagged in the same slot.
  assign em_load  = em_memread & ~em_memwrite;
  assign em_store = em_valid & em_memwrite;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      em_valid    <= 1'b0;
      em_regwrite <= 1'b0;
      em_memread  <= 1'b0;
      em_memwrite <= 1'b0;
      em_rd       <= '0;
      em_alu      <= '0;
      em_sdata    <= '0;
      mw_valid    <= 1'b0;
      mw_regwrite <= 1'b0;
      mw_rd       <= '0;
      mw_data     <= '0;
      store_cnt   <= 8'd0;
      for (int i = 0; i < DEPTH; i++) dmem[i] <= '0;
    end else begin
      em_valid    <= ex_valid;
      em_regwrite <= ex_regwrite;
      em_memread  <= ex_memread;
      em_memwrite <= ex_memwrite;
      em_rd       <= ex_rd;
      em_alu      <= ex_alu_out;
      em_sdata    <= ex_store_data;
      mw_valid    <= em_valid;
      mw_regwrite <= em_regwrite;
      mw_rd       <= em_rd;
      mw_data     <= em_load ? rd_data : em_alu;
      if (em_store) begin
        dmem[addr] <= em_sdata;
        store_cnt  <= store_cnt + 8'd1;
      end
    end
  end

  assign exmem_alu = em_alu;
  assign wb_we     = mw_valid & mw_regwrite & (mw_rd != '0);
  assign wb_wa     = mw_rd;
  assign wb_wd     = mw_data;

  // Loads in EX/MEM are never forwarded; the hazard unit stalls behind them.
  assign em_fwd_ok = em_valid & em_regwrite & ~em_memread & (em_rd != '0);

  always_comb begin
    forwardA = 2'b00;
    forwardB = 2'b00;
    if (em_fwd_ok && (em_rd == id_ex_rs))   forwardA = 2'b10;
    else if (wb_we && (wb_wa == id_ex_rs))  forwardA = 2'b01;
    if (em_fwd_ok && (em_rd == id_ex_rt))   forwardB = 2'b10;
    else if (wb_we && (wb_wa == id_ex_rt))  forwardB = 2'b01;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, a table of pipelined vectors,
// then counter-wrap, bubble-store and mid-operation reset sequences.
module tb_mem_wb_stage;

  logic       clk = 1'b0;
  logic       rstn;
  logic       ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [2:0] ex_rd;
  logic [7:0] ex_alu_out, ex_store_data;
  logic [2:0] id_ex_rs, id_ex_rt;
  logic [7:0] exmem_alu;
  logic       wb_we;
  logic [2:0] wb_wa;
  logic [7:0] wb_wd;
  logic [1:0] forward_a, forward_b;
  logic [7:0] store_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  mem_wb_stage dut (
    .clk(clk), .rstn(rstn),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_rd(ex_rd), .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
    .exmem_alu(exmem_alu), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .forwardA(forward_a), .forwardB(forward_b), .store_cnt(store_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v, rw, mr, mwr;
    logic [2:0] rd;
    logic [7:0] alu, sd;
    logic [2:0] rs, rt;
    logic       e_we;
    logic [2:0] e_wa;
    logic [7:0] e_wd, e_ea;
    logic [1:0] e_fa, e_fb;
    logic [7:0] e_cnt;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(logic v, logic rw, logic mr, logic mwr, logic [2:0] rd,
                              logic [7:0] alu, logic [7:0] sd, logic [2:0] rs, logic [2:0] rt,
                              logic e_we, logic [2:0] e_wa, logic [7:0] e_wd, logic [7:0] e_ea,
                              logic [1:0] e_fa, logic [1:0] e_fb, logic [7:0] e_cnt);
    vec_t r;
    r.v = v; r.rw = rw; r.mr = mr; r.mwr = mwr; r.rd = rd; r.alu = alu; r.sd = sd;
    r.rs = rs; r.rt = rt; r.e_we = e_we; r.e_wa = e_wa; r.e_wd = e_wd; r.e_ea = e_ea;
    r.e_fa = e_fa; r.e_fb = e_fb; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic rw, logic mr, logic mwr, logic [2:0] rd,
                       logic [7:0] alu, logic [7:0] sd, logic [2:0] rs, logic [2:0] rt);
    ex_valid = v; ex_regwrite = rw; ex_memread = mr; ex_memwrite = mwr;
    ex_rd = rd; ex_alu_out = alu; ex_store_data = sd; id_ex_rs = rs; id_ex_rt = rt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    drive(0, 0, 0, 0, 3'd0, 8'h00, 8'h00, 3'd0, 3'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Cols: v rw mr mwr rd alu sd rs rt | we wa wd exmem_alu fa fb cnt
    vecs[0]  = mk(1,1,0,0,3'd3,8'h5A,8'h00,3'd0,3'd0, 0,3'd0,8'h00,8'h5A,2'b00,2'b00,8'd0);
    vecs[1]  = mk(0,0,0,0,3'd0,8'h00,8'h00,3'd3,3'd0, 1,3'd3,8'h5A,8'h00,2'b01,2'b00,8'd0);
    vecs[2]  = mk(1,1,0,0,3'd0,8'h33,8'h00,3'd0,3'd0, 0,3'd0,8'h00,8'h33,2'b00,2'b00,8'd0);
    vecs[3]  = mk(0,0,0,0,3'd0,8'h00,8'h00,3'd0,3'd0, 0,3'd0,8'h33,8'h00,2'b00,2'b00,8'd0);
    vecs[4]  = mk(1,0,0,1,3'd0,8'h15,8'h77,3'd0,3'd0, 0,3'd0,8'h00,8'h15,2'b00,2'b00,8'd0);
    vecs[5]  = mk(1,1,1,0,3'd2,8'h05,8'h00,3'd0,3'd0, 0,3'd0,8'h15,8'h05,2'b00,2'b00,8'd1);
    vecs[6]  = mk(0,0,0,0,3'd0,8'h00,8'h00,3'd2,3'd2, 1,3'd2,8'h77,8'h00,2'b01,2'b01,8'd1);
    vecs[7]  = mk(1,1,0,0,3'd4,8'h44,8'h00,3'd0,3'd0, 0,3'd0,8'h00,8'h44,2'b00,2'b00,8'd1);
    vecs[8]  = mk(1,1,0,0,3'd4,8'h88,8'h00,3'd4,3'd4, 1,3'd4,8'h44,8'h88,2'b10,2'b10,8'd1);
    vecs[9]  = mk(0,0,0,0,3'd0,8'h00,8'h00,3'd4,3'd4, 1,3'd4,8'h88,8'h00,2'b01,2'b01,8'd1);
    vecs[10] = mk(1,1,1,0,3'd4,8'h05,8'h00,3'd0,3'd4, 0,3'd0,8'h00,8'h05,2'b00,2'b00,8'd1);
    vecs[11] = mk(1,1,1,0,3'd5,8'h05,8'h00,3'd5,3'd4, 1,3'd4,8'h77,8'h05,2'b00,2'b01,8'd1);
    vecs[12] = mk(0,1,0,1,3'd6,8'h05,8'hEE,3'd6,3'd0, 1,3'd5,8'h77,8'h05,2'b00,2'b00,8'd1);
    vecs[13] = mk(1,1,1,0,3'd3,8'h05,8'h00,3'd0,3'd0, 0,3'd6,8'h05,8'h05,2'b00,2'b00,8'd1);
    vecs[14] = mk(0,0,0,0,3'd0,8'h00,8'h00,3'd0,3'd0, 1,3'd3,8'h77,8'h00,2'b00,2'b00,8'd1);
    vecs[15] = mk(1,1,1,1,3'd7,8'h0A,8'h99,3'd0,3'd0, 0,3'd0,8'h00,8'h0A,2'b00,2'b00,8'd1);
    vecs[16] = mk(1,1,1,0,3'd1,8'h0A,8'h00,3'd7,3'd0, 1,3'd7,8'h0A,8'h0A,2'b01,2'b00,8'd2);
    vecs[17] = mk(0,0,0,0,3'd0,8'h00,8'h00,3'd1,3'd0, 1,3'd1,8'h99,8'h00,2'b01,2'b00,8'd2);

    rstn = 1'b0;
    bubble();
    tick();
    rstn = 1'b1;

    // Fill memory with non-zero data so the reset clear is observable.
    for (int a = 0; a < 16; a++) begin
      drive(1, 0, 0, 1, 3'd0, 8'(a), 8'hAA, 3'd0, 3'd0);
      tick();
    end
    bubble();
    tick();

    rstn = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
            8'($urandom), 8'($urandom), 3'($urandom), 3'($urandom));
      tick();
    end
    check("rst_wb_we", {7'd0, wb_we}, 8'h00);
    check("rst_wb_wa", {5'd0, wb_wa}, 8'h00);
    check("rst_wb_wd", wb_wd, 8'h00);
    check("rst_exmem_alu", exmem_alu, 8'h00);
    check("rst_fwd_a", {6'd0, forward_a}, 8'h00);
    check("rst_fwd_b", {6'd0, forward_b}, 8'h00);
    check("rst_store_cnt", store_cnt, 8'h00);
    rstn = 1'b1;

    for (int a = 0; a < 16; a++) begin
      drive(1, 1, 1, 0, 3'd1, 8'(a), 8'h00, 3'd0, 3'd0);
      tick();
      bubble();
      tick();
      check($sformatf("rst_dmem%0d_we", a), {7'd0, wb_we}, 8'h01);
      check($sformatf("rst_dmem%0d", a), wb_wd, 8'h00);
    end
    bubble();
    tick();
    tick();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, vecs[i].rw, vecs[i].mr, vecs[i].mwr, vecs[i].rd,
            vecs[i].alu, vecs[i].sd, vecs[i].rs, vecs[i].rt);
      tick();
      check($sformatf("vec%0d_wb_we", i), {7'd0, wb_we}, {7'd0, vecs[i].e_we});
      check($sformatf("vec%0d_wb_wa", i), {5'd0, wb_wa}, {5'd0, vecs[i].e_wa});
      check($sformatf("vec%0d_wb_wd", i), wb_wd, vecs[i].e_wd);
      check($sformatf("vec%0d_exmem_alu", i), exmem_alu, vecs[i].e_ea);
      check($sformatf("vec%0d_fwd_a", i), {6'd0, forward_a}, {6'd0, vecs[i].e_fa});
      check($sformatf("vec%0d_fwd_b", i), {6'd0, forward_b}, {6'd0, vecs[i].e_fb});
      check($sformatf("vec%0d_store_cnt", i), store_cnt, vecs[i].e_cnt);
    end

    // Counter wrap: restart from zero, then 256 consecutive committed stores.
    rstn = 1'b0;
    bubble();
    tick();
    rstn = 1'b1;
    check("wrap_start", store_cnt, 8'd0);
    for (int i = 0; i < 256; i++) begin
      drive(1, 0, 0, 1, 3'd0, 8'(i), 8'(i), 3'd0, 3'd0);
      tick();
    end
    check("wrap_cnt_255", store_cnt, 8'd255);
    bubble();
    tick();
    check("wrap_cnt_0", store_cnt, 8'd0);

    // Bubble carrying a store must neither write nor count.
    drive(0, 0, 0, 1, 3'd0, 8'h03, 8'hEE, 3'd0, 3'd0);
    tick();
    bubble();
    tick();
    check("bubble_store_cnt", store_cnt, 8'd0);
    drive(1, 1, 1, 0, 3'd2, 8'h03, 8'h00, 3'd0, 3'd0);
    tick();
    bubble();
    tick();
    check("bubble_store_mem", wb_wd, 8'hF3);

    // Store pending in EX/MEM at a reset edge is dropped.
    drive(1, 0, 0, 1, 3'd0, 8'h02, 8'h5C, 3'd0, 3'd0);
    tick();
    rstn = 1'b0;
    bubble();
    tick();
    rstn = 1'b1;
    check("midrst_cnt", store_cnt, 8'd0);
    drive(1, 1, 1, 0, 3'd1, 8'h02, 8'h00, 3'd0, 3'd0);
    tick();
    bubble();
    tick();
    check("midrst_mem", wb_wd, 8'h00);
    check("midrst_cnt2", store_cnt, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
